// File: rtl/cpu_bus_responder.sv
// CPU-side bus responder: mirrored byte RAM plus two serial joypad ports.
// Define CPU_BUS_JOYPAD2_EN to implement the second controller shift register.
module cpu_bus_responder #(
  parameter int RAM_AW = 11
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic [15:0] address_bus_in,
  input  logic [7:0]  data_bus_in,
  input  logic        wen,
  input  logic        ren,
  input  logic [7:0]  pad1_buttons,
  input  logic [7:0]  pad2_buttons,
  output logic [7:0]  data_bus_out,
  output logic        data_valid
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [7:0]        ram_q [RAM_DEPTH];
  logic [7:0]        ram_rd_q;
  logic [RAM_AW-1:0] ram_idx;

  logic ram_sel, pad1_sel, pad2_sel;
  logic wr_en, rd_en;

  logic       strobe_q, strobe_d;
  logic [7:0] shift1_q, shift1_d;
  logic [7:0] out_q, out_d;
  logic       src_ram_q, src_ram_d;
  logic       valid_q, valid_d;

  assign ram_idx  = address_bus_in[RAM_AW-1:0];
  assign ram_sel  = (address_bus_in[15:13] == 3'b000);
  assign pad1_sel = (address_bus_in == 16'h4016);
  assign pad2_sel = (address_bus_in == 16'h4017);

  // Reset overrides bus activity; a write wins over a simultaneous read.
  assign wr_en = wen & ~reset;
  assign rd_en = ren & ~wen & ~reset;

  // RAM kept reset-free with a registered read so it maps onto block RAM.
  always_ff @(posedge cpu_clk) begin
    if (wr_en && ram_sel) begin
      ram_q[ram_idx] <= data_bus_in;
    end
    if (rd_en && ram_sel) begin
      ram_rd_q <= ram_q[ram_idx];
    end
  end

`ifdef CPU_BUS_JOYPAD2_EN
  logic [7:0] shift2_q, shift2_d;

  always_comb begin
    shift2_d = shift2_q;
    if (strobe_q) begin
      shift2_d = pad2_buttons;
    end else if (rd_en && pad2_sel) begin
      shift2_d = {1'b1, shift2_q[7:1]};
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      shift2_q <= 8'h00;
    end else begin
      shift2_q <= shift2_d;
    end
  end
`else
  logic unused_pad2;
  assign unused_pad2 = ^pad2_buttons;
`endif

  always_comb begin
    strobe_d  = strobe_q;
    shift1_d  = shift1_q;
    out_d     = out_q;
    src_ram_d = src_ram_q;
    valid_d   = 1'b0;

    if (wr_en && pad1_sel) begin
      strobe_d = data_bus_in[0];
    end

    if (strobe_q) begin
      shift1_d = pad1_buttons;
    end else if (rd_en && pad1_sel) begin
      shift1_d = {1'b1, shift1_q[7:1]};
    end

    if (rd_en) begin
      valid_d   = 1'b1;
      src_ram_d = ram_sel;
      if (pad1_sel) begin
        out_d = {7'b0100000, strobe_q ? pad1_buttons[0] : shift1_q[0]};
      end else if (pad2_sel) begin
`ifdef CPU_BUS_JOYPAD2_EN
        out_d = {7'b0100000, strobe_q ? pad2_buttons[0] : shift2_q[0]};
`else
        out_d = 8'h40;
`endif
      end else begin
        out_d = 8'h00;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      strobe_q  <= 1'b0;
      shift1_q  <= 8'h00;
      out_q     <= 8'h00;
      src_ram_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      strobe_q  <= strobe_d;
      shift1_q  <= shift1_d;
      out_q     <= out_d;
      src_ram_q <= src_ram_d;
      valid_q   <= valid_d;
    end
  end

  // RAM reads come straight from the block RAM output register.
  assign data_bus_out = src_ram_q ? ram_rd_q : out_q;
  assign data_valid   = valid_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed, table-driven bench for cpu_bus_responder; one line per vector.
module tb_cpu_bus_responder;

  logic        cpu_clk;
  logic        reset;
  logic [15:0] address_bus_in;
  logic [7:0]  data_bus_in;
  logic        wen;
  logic        ren;
  logic [7:0]  pad1_buttons;
  logic [7:0]  pad2_buttons;
  logic [7:0]  data_bus_out;
  logic        data_valid;

`ifdef CPU_BUS_JOYPAD2_EN
  localparam logic [7:0] P2_EXP = 8'h41;
`else
  localparam logic [7:0] P2_EXP = 8'h40;
`endif

  cpu_bus_responder #(.RAM_AW(11)) dut (
    .cpu_clk        (cpu_clk),
    .reset          (reset),
    .address_bus_in (address_bus_in),
    .data_bus_in    (data_bus_in),
    .wen            (wen),
    .ren            (ren),
    .pad1_buttons   (pad1_buttons),
    .pad2_buttons   (pad2_buttons),
    .data_bus_out   (data_bus_out),
    .data_valid     (data_valid)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        exp_v;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_cmp;
  int   n_bad;

  task automatic add(input logic rst, input logic we, input logic re,
                     input logic [15:0] addr, input logic [7:0] wd,
                     input logic [7:0] p1, input logic [7:0] p2,
                     input logic exp_v, input logic [7:0] exp_d);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re; v.addr = addr; v.wd = wd;
    v.p1 = p1; v.p2 = p2; v.exp_v = exp_v; v.exp_d = exp_d;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then check the outputs just after the edge.
  task automatic step(input string name, input vec_t v);
    @(negedge cpu_clk);
    reset          = v.rst;
    wen            = v.we;
    ren            = v.re;
    address_bus_in = v.addr;
    data_bus_in    = v.wd;
    pad1_buttons   = v.p1;
    pad2_buttons   = v.p2;
    @(posedge cpu_clk);
    #1;
    n_vec++;
    n_cmp++;
    if (data_valid !== v.exp_v) begin
      n_bad++;
      $display("FAIL %s valid: got %b want %b", name, data_valid, v.exp_v);
    end
    n_cmp++;
    if (data_bus_out !== v.exp_d) begin
      n_bad++;
      $display("FAIL %s data: got %02h want %02h", name, data_bus_out, v.exp_d);
    end
    $display("%s rst=%b we=%b re=%b addr=%04h wd=%02h -> valid=%b data=%02h",
             name, v.rst, v.we, v.re, v.addr, v.wd, data_valid, data_bus_out);
  endtask

  initial begin
    vec_t v;
    n_vec = 0; n_cmp = 0; n_bad = 0;
    reset = 1'b1; wen = 1'b0; ren = 1'b0;
    address_bus_in = 16'h0000; data_bus_in = 8'h00;
    pad1_buttons = 8'h00; pad2_buttons = 8'h00;

    //   rst we re addr     wd     p1     p2     v  data
    add(1, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    add(1, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    // RAM write then mirrored read on the next cycle
    add(0, 1, 0, 16'h0005, 8'hA5, 8'h00, 8'h00, 0, 8'h00);
    add(0, 0, 1, 16'h1805, 8'h00, 8'h00, 8'h00, 1, 8'hA5);
    add(0, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'hA5);
    // Latch pad1=0x09 and shift out ten bits
    add(0, 1, 0, 16'h4016, 8'h01, 8'h09, 8'h00, 0, 8'hA5);
    add(0, 1, 0, 16'h4016, 8'h00, 8'h09, 8'h00, 0, 8'hA5);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h41);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h40);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h40);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h41);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h40);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h40);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h40);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h40);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h41);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h09, 8'h00, 1, 8'h41);
    // Strobe held high: reads follow live A
    add(0, 1, 0, 16'h4016, 8'h01, 8'h00, 8'h00, 0, 8'h41);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h01, 8'h00, 1, 8'h41);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h00, 8'h00, 1, 8'h40);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h01, 8'h00, 1, 8'h41);
    add(0, 1, 0, 16'h4016, 8'h00, 8'h00, 8'h00, 0, 8'h41);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h01, 8'h00, 1, 8'h40);
    // Write and read together: write wins, no valid
    add(0, 1, 1, 16'h0010, 8'h3C, 8'h00, 8'h00, 0, 8'h40);
    add(0, 0, 1, 16'h0010, 8'h00, 8'h00, 8'h00, 1, 8'h3C);
    // Reset mid-shift, concurrent with a read
    add(0, 1, 0, 16'h4016, 8'h01, 8'h06, 8'h00, 0, 8'h3C);
    add(0, 1, 0, 16'h4016, 8'h00, 8'h06, 8'h00, 0, 8'h3C);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h06, 8'h00, 1, 8'h40);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h06, 8'h00, 1, 8'h41);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h06, 8'h00, 1, 8'h41);
    add(1, 0, 1, 16'h4016, 8'h00, 8'h06, 8'h00, 0, 8'h00);
    add(0, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h00);
    add(0, 1, 0, 16'h4016, 8'h01, 8'hFF, 8'h00, 0, 8'h00);
    add(0, 1, 0, 16'h4016, 8'h00, 8'hFF, 8'h00, 0, 8'h00);
    add(0, 0, 1, 16'h4016, 8'h00, 8'h00, 8'h00, 1, 8'h41);
    // Unmapped read and port 2
    add(0, 0, 1, 16'h2000, 8'h00, 8'h00, 8'h00, 1, 8'h00);
    add(0, 1, 0, 16'h4016, 8'h01, 8'h00, 8'h01, 0, 8'h00);
    add(0, 1, 0, 16'h4016, 8'h00, 8'h00, 8'h01, 0, 8'h00);
    add(0, 0, 1, 16'h4017, 8'h00, 8'h00, 8'h00, 1, P2_EXP);
    // Top-of-RAM mirror, then another unmapped address
    add(0, 1, 0, 16'h07FF, 8'h5A, 8'h00, 8'h00, 0, P2_EXP);
    add(0, 0, 1, 16'h1FFF, 8'h00, 8'h00, 8'h00, 1, 8'h5A);
    add(0, 0, 1, 16'h4018, 8'h00, 8'h00, 8'h00, 1, 8'h00);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // RAM survives reset; 0x4017 writes don't touch strobe.
    v = '{0, 1, 0, 16'h0020, 8'h77, 8'h00, 8'h00, 0, 8'h00};
    step("seq_ram_wr", v);
    v = '{1, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h00};
    step("seq_reset", v);
    v = '{0, 0, 1, 16'h0820, 8'h00, 8'h00, 8'h00, 1, 8'h77};
    step("seq_ram_rd", v);
    v = '{0, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 8'h77};
    step("seq_pulse_end", v);
    v = '{0, 1, 0, 16'h4017, 8'h01, 8'h01, 8'h00, 0, 8'h77};
    step("seq_wr4017", v);
    v = '{0, 0, 1, 16'h4016, 8'h00, 8'h01, 8'h00, 1, 8'h40};
    step("seq_no_strobe", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
